// File: rtl/bnn_xnor_accum.sv
// Binary neuron stage: XNOR-popcount over CHUNKS 8-bit beats, one result per neuron.
// Result one cycle after the final beat; input stalls while a result is pending.
module bnn_xnor_accum #(
  parameter int CHUNKS = 4,
  localparam int ACC_W = $clog2(8*CHUNKS+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_act,
  input  logic [7:0]       in_wgt,
  input  logic [ACC_W-1:0] in_thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [ACC_W:0]   out_dot,
  output logic             out_bit
);

  localparam int CW = $clog2(CHUNKS+1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [ACC_W:0] FANIN = (ACC_W+1)'(8*CHUNKS);
  localparam logic [CW-1:0]  LAST  = CW'(CHUNKS-1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] thr;

  logic             accept;
  logic             last_beat;
  logic [3:0]       pc;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] thr_eff;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b0, v[i]};
    return n;
  endfunction

  assign in_ready  = !rst && (state == IDLE || state == ACCUM);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign pc        = popcount8(~(in_act ^ in_wgt));

  // The first beat of a neuron starts from zero and uses the live threshold,
  // so a single-beat neuron still resolves its result in one cycle.
  always_comb begin
    acc_next  = ((state == IDLE) ? '0 : acc) + ACC_W'(pc);
    thr_eff   = (state == IDLE) ? in_thresh : thr;
    last_beat = (state == IDLE) ? (CHUNKS == 1) : (cnt == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      thr     <= '0;
      out_sum <= '0;
      out_dot <= '0;
      out_bit <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc <= acc_next;
            thr <= thr_eff;
            cnt <= (state == IDLE) ? CW'(1) : cnt + 1'b1;
            if (last_beat) begin
              state   <= DONE;
              out_sum <= acc_next;
              out_dot <= {acc_next, 1'b0} - FANIN;
              out_bit <= (acc_next >= thr_eff);
            end else begin
              state <= ACCUM;
            end
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_xnor_accum.sv
// Randomized and directed bench for bnn_xnor_accum against a bit-counting reference.
module tb_bnn_xnor_accum;
  localparam int CHUNKS = 4;
  localparam int NB     = 8*CHUNKS;
  localparam int ACC_W  = $clog2(NB+1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_act;
  logic [7:0]       in_wgt;
  logic [ACC_W-1:0] in_thresh;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [ACC_W:0]   out_dot;
  logic             out_bit;

  int checks = 0;
  int errors = 0;

  bnn_xnor_accum #(.CHUNKS(CHUNKS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_wgt(in_wgt), .in_thresh(in_thresh),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_dot(out_dot), .out_bit(out_bit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: count agreeing bit positions over the whole fan-in.
  function automatic int ref_sum(input logic [NB-1:0] a, input logic [NB-1:0] w);
    int s = 0;
    for (int i = 0; i < NB; i++) if (a[i] == w[i]) s++;
    return s;
  endfunction

  task automatic send_beat(input logic [7:0] a, input logic [7:0] w,
                           input logic [ACC_W-1:0] th);
    int t = 0;
    in_valid = 1'b1; in_act = a; in_wgt = w; in_thresh = th;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    check("beat_accept_timeout", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_act = 8'($urandom); in_wgt = 8'($urandom); in_thresh = ACC_W'($urandom);
  endtask

  task automatic run_neuron(input string tag, input logic [NB-1:0] a,
                            input logic [NB-1:0] w, input logic [ACC_W-1:0] th,
                            input int max_gap, input int hold);
    int s, d, b;
    s = ref_sum(a, w);
    d = 2*s - NB;
    b = (s >= int'(th)) ? 1 : 0;
    for (int k = 0; k < CHUNKS; k++) begin
      if (k > 0 && max_gap > 0) repeat ($urandom_range(1, max_gap)) begin
        @(posedge clk); #1;
      end
      send_beat(a[8*k +: 8], w[8*k +: 8], (k == 0) ? th : ACC_W'($urandom));
    end
    check({tag, "_latency_valid"}, 32'(out_valid), 1);
    check({tag, "_in_ready_low"}, 32'(in_ready), 0);
    if (hold > 0) begin
      in_valid = 1'b1; in_act = 8'($urandom); in_wgt = 8'($urandom);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        check({tag, "_hold_valid"}, 32'(out_valid), 1);
        check({tag, "_hold_ready"}, 32'(in_ready), 0);
        check({tag, "_hold_sum"}, 32'(out_sum), s);
      end
      in_valid = 1'b0;
    end
    check({tag, "_sum"}, 32'(out_sum), s);
    check({tag, "_dot"}, $signed(out_dot), d);
    check({tag, "_bit"}, 32'(out_bit), b);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_dropped"}, 32'(out_valid), 0);
    check({tag, "_ready_after_hs"}, 32'(in_ready), 1);
  endtask

  initial begin
    logic [NB-1:0] ra, rw;
    rst = 1'b1; in_valid = 1'b0; in_act = '0; in_wgt = '0; in_thresh = '0;
    out_ready = 1'b0;
    #3;
    check("reset_in_ready", 32'(in_ready), 0);
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_out_sum", 32'(out_sum), 0);
    check("reset_out_dot", 32'(out_dot), 0);
    check("reset_out_bit", 32'(out_bit), 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_neuron("all_match", {CHUNKS{8'hA5}}, {CHUNKS{8'hA5}}, 6'd16, 0, 0);
    run_neuron("all_match_th33", {CHUNKS{8'hA5}}, {CHUNKS{8'hA5}}, 6'd33, 0, 0);
    run_neuron("mismatch_th1", {CHUNKS{8'hFF}}, {CHUNKS{8'h00}}, 6'd1, 0, 0);
    run_neuron("mismatch_th0", {CHUNKS{8'hFF}}, {CHUNKS{8'h00}}, 6'd0, 0, 0);
    run_neuron("mixed_th16", 32'h0F_0F_F0_FF, 32'h00_00_0F_FF, 6'd16, 0, 0);
    run_neuron("mixed_th17", 32'h0F_0F_F0_FF, 32'h00_00_0F_FF, 6'd17, 0, 0);

    ra = NB'($urandom); rw = NB'($urandom);
    run_neuron("backpressure", ra, rw, ACC_W'($urandom_range(0, 40)), 0, 5);
    ra = NB'($urandom); rw = NB'($urandom);
    run_neuron("after_release", ra, rw, ACC_W'($urandom_range(0, 40)), 0, 0);
    run_neuron("bubbles", ra, rw, ACC_W'($urandom_range(0, 40)), 3, 0);

    // Abandon a neuron after two beats while old outputs are still nonzero.
    send_beat(8'hFF, 8'hFF, 6'd5);
    send_beat(8'hFF, 8'hFF, 6'd5);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_out_sum", 32'(out_sum), 0);
    check("midrst_out_dot", 32'(out_dot), 0);
    check("midrst_out_bit", 32'(out_bit), 0);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_in_ready", 32'(in_ready), 0);
    @(posedge clk); @(negedge clk);
    check("midrst_no_valid", 32'(out_valid), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_neuron("post_reset", {CHUNKS{8'h0F}}, {CHUNKS{8'h00}}, 6'd8, 0, 0);

    for (int n = 0; n < 20; n++) begin
      ra = NB'($urandom); rw = NB'($urandom);
      if (n % 5 == 0) rw = ra ^ NB'(1 << $urandom_range(0, NB-1));
      run_neuron("random", ra, rw, ACC_W'($urandom_range(0, 40)),
                 $urandom_range(0, 3), (n % 4 == 1) ? $urandom_range(1, 4) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
